settings_cmd_master: RTL
========================

Name: settings_cmd_master

Overview:
- Command-side initiator for the settings ROM/RAM register memory.
- Parses a byte stream from the host link (UART receiver output) into register read/write transactions.
- Drives the memory's wen/addr/data_in bus and captures its data_out.
- Returns acknowledge, read-data or error bytes on a valid/ready transmit stream toward the link transmitter.

Parameters:
- MEMORY_WIDTH, 16: register data width. Only 16 is supported: two bytes, big-endian.
- ROM_MEMORY_LENGTH, 16: number of read-only words, at addresses 0..ROM_MEMORY_LENGTH-1.
- RAM_MEMORY_LENGTH, 16: number of read/write words, at addresses ROM_MEMORY_LENGTH..ROM_MEMORY_LENGTH+RAM_MEMORY_LENGTH-1.
- READ_LATENCY, 1: cycles from addr valid to data_out valid at the memory.
- TIMEOUT_CYCLES, 100000: maximum idle cycles allowed between bytes of one command.

Ports:
- clk input 1: system clock; all logic on the rising edge.
- rstb input 1: reset, synchronous, active-high.
- rx_data input 8: received byte.
- rx_valid input 1: one-cycle strobe; rx_data is valid in that cycle.
- tx_data output 8: response byte.
- tx_valid output 1: response byte is pending.
- tx_ready input 1: downstream accepts tx_data in a cycle where tx_valid=1.
- wen output 1: memory write enable, one-cycle pulse.
- addr output $clog2(ROM_MEMORY_LENGTH+RAM_MEMORY_LENGTH): memory address.
- data_in output MEMORY_WIDTH: memory write data.
- data_out input MEMORY_WIDTH: memory read data.
- busy output 1: high in every state except IDLE.
- err_timeout output 1: one-cycle pulse when a partial command is abandoned.

Behaviour:
- Reset values: wen=0, addr=0, data_in=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0; state=IDLE; timeout counter=0.
- Reset mid-command or mid-response aborts immediately; a pending tx byte is dropped.
- Command formats:
  - Write: 0x57 'W', ADDR, DHI, DLO.
  - Read: 0x52 'R', ADDR.
- Response formats:
  - Successful write: 0x41 'A'.
  - Successful read: DHI then DLO.
  - Any error: 0x45 'E'.
- State transitions:
  - IDLE: rx 0x57 -> GET_ADDR with op=write; rx 0x52 -> GET_ADDR with op=read; any other byte -> SEND_ERR.
  - GET_ADDR: on rx, latch the byte.
    - Byte >= ROM_MEMORY_LENGTH+RAM_MEMORY_LENGTH -> SEND_ERR (for a write, remaining bytes are not consumed).
    - Write to an address < ROM_MEMORY_LENGTH -> SEND_ERR.
    - Otherwise: write -> GET_DHI; read -> READ_WAIT with addr driven from the next cycle.
  - GET_DHI: on rx, latch the high byte -> GET_DLO.
  - GET_DLO: on rx, latch the low byte -> WRITE.
  - WRITE: addr and data_in are stable; wen=1 for exactly this cycle -> SEND_ACK.
  - READ_WAIT: count READ_LATENCY cycles after addr is stable, then capture data_out into a holding register -> SEND_HI.
  - SEND_HI / SEND_LO / SEND_ACK / SEND_ERR:
    - tx_valid=1 with tx_data held constant until the cycle where tx_valid&&tx_ready.
    - Transfer sequence: SEND_HI -> SEND_LO -> IDLE; SEND_ACK -> IDLE; SEND_ERR -> IDLE.
    - tx_valid deasserts in the cycle after the final accept unless a new byte is loaded.
- addr and data_in hold their last values after a transaction; they change only when a new command loads them.
- Timeout: the counter clears on every rx_valid and counts in GET_ADDR, GET_DHI and GET_DLO. On reaching TIMEOUT_CYCLES: return to IDLE, pulse err_timeout, send no response.
- rx_valid in any WRITE, READ_WAIT or SEND_* state: byte is ignored, no buffering. The host must wait for the response.
- rx_valid and tx_ready in the same cycle: both are honoured independently.
- At most one wen pulse per command, and never on error or timeout.

Test Plan:
- Write then read RAM: rx 57 10 BE EF -> wen=1 for one cycle with addr=0x10, data_in=0xBEEF; tx 41. Then rx 52 10 -> tx BE, EF.
- Read ROM: rom_data_3=0x1234, rx 52 03 -> no wen; tx 12 then 34; busy returns low after the second accept.
- Errors:
  - rx 57 05 (ROM address) -> tx 45, no wen.
  - rx 52 20 (out of range) -> tx 45.
  - rx 33 -> tx 45.
- Backpressure: tx_ready=0 for 10 cycles during a read -> tx_data=hi byte held stable and tx_valid=1 throughout. Bytes then complete in order, each accepted exactly once.
- Timeout: with TIMEOUT_CYCLES=50, rx 57 10 then idle -> err_timeout pulses once, no wen, no tx. A following rx 52 10 is handled normally.
- Reset mid-response: assert rstb for 1 cycle while tx_valid=1 -> the next cycle has all outputs at reset values and the state is IDLE.

Source files
------------

// File: rtl/settings_cmd_master_if.sv
// Command-side bus bundle for the settings register master: host byte
// stream in, response byte stream out, memory port and status flags.
interface settings_cmd_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  err_timeout;

    modport master (
        input  rx_data, rx_valid, tx_ready, data_out,
        output tx_data, tx_valid, wen, addr, data_in, busy, err_timeout
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, data_out,
        input  tx_data, tx_valid, wen, addr, data_in, busy, err_timeout
    );
endinterface

// File: rtl/settings_cmd_master.sv
// Settings command master: turns host bytes ('W' ADDR DHI DLO / 'R' ADDR)
// into register memory accesses and returns 'A', DHI DLO or 'E' bytes.
// Addresses below ROM_MEMORY_LENGTH are read-only; data is big-endian.
module settings_cmd_master #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int ROM_MEMORY_LENGTH = 16,
    parameter int RAM_MEMORY_LENGTH = 16,
    parameter int READ_LATENCY      = 1,
    parameter int TIMEOUT_CYCLES    = 100000
) (
    input  logic                 clk,
    input  logic                 rstb,
    settings_cmd_master_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH);
    localparam int TO_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RL_WIDTH   = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [8:0]          ADDR_LIMIT = 9'(ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH);
    localparam logic [8:0]          ROM_LIMIT  = 9'(ROM_MEMORY_LENGTH);
    localparam logic [TO_WIDTH-1:0] TO_LAST    = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] TO_ONE     = TO_WIDTH'(1);
    localparam logic [RL_WIDTH-1:0] RL_LAST    = RL_WIDTH'(READ_LATENCY);
    localparam logic [RL_WIDTH-1:0] RL_ONE     = RL_WIDTH'(1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_GET_ADDR  = 4'd1;
    localparam logic [3:0] ST_GET_DHI   = 4'd2;
    localparam logic [3:0] ST_GET_DLO   = 4'd3;
    localparam logic [3:0] ST_WRITE     = 4'd4;
    localparam logic [3:0] ST_READ_WAIT = 4'd5;
    localparam logic [3:0] ST_SEND_HI   = 4'd6;
    localparam logic [3:0] ST_SEND_LO   = 4'd7;
    localparam logic [3:0] ST_SEND_ACK  = 4'd8;
    localparam logic [3:0] ST_SEND_ERR  = 4'd9;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h41;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    logic [3:0]              state_r, state_s;
    logic                    op_write_r, op_write_s;
    logic [ADDR_WIDTH-1:0]   addr_lat_r, addr_lat_s;
    logic [7:0]              dhi_r, dhi_s;
    logic [7:0]              hold_lo_r, hold_lo_s;
    logic [RL_WIDTH-1:0]     wait_cnt_r, wait_cnt_s;
    logic [TO_WIDTH-1:0]     to_cnt_r, to_cnt_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [MEMORY_WIDTH-1:0] data_in_r, data_in_s;
    logic                    wen_r, wen_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    tx_valid_r, tx_valid_s;
    logic                    err_timeout_r, err_timeout_s;
    logic                    busy_r;

    logic                    tx_accept_s;
    logic                    in_get_s;
    logic                    timeout_hit_s;
    logic [8:0]              addr_byte_s;
    logic                    addr_bad_s;

    // Handshake, timeout and address-legality decodes shared by the FSM.
    always_comb begin
        tx_accept_s   = tx_valid_r & bus.tx_ready;
        in_get_s      = (state_r == ST_GET_ADDR) || (state_r == ST_GET_DHI) ||
                        (state_r == ST_GET_DLO);
        timeout_hit_s = in_get_s && !bus.rx_valid && (to_cnt_r == TO_LAST);
        addr_byte_s   = {1'b0, bus.rx_data};
        addr_bad_s    = (addr_byte_s >= ADDR_LIMIT) ||
                        (op_write_r && (addr_byte_s < ROM_LIMIT));
    end

    // Inter-byte idle counter: only runs while a command is partially received.
    always_comb begin
        if (!in_get_s || bus.rx_valid || timeout_hit_s) begin
            to_cnt_s = {TO_WIDTH{1'b0}};
        end else begin
            to_cnt_s = to_cnt_r + TO_ONE;
        end
    end

    // Command/response sequencer: next state and next register values.
    always_comb begin
        state_s       = state_r;
        op_write_s    = op_write_r;
        addr_lat_s    = addr_lat_r;
        dhi_s         = dhi_r;
        hold_lo_s     = hold_lo_r;
        wait_cnt_s    = wait_cnt_r;
        addr_s        = addr_r;
        data_in_s     = data_in_r;
        wen_s         = 1'b0;
        tx_data_s     = tx_data_r;
        tx_valid_s    = tx_valid_r;
        err_timeout_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WRITE) begin
                        op_write_s = 1'b1;
                        state_s    = ST_GET_ADDR;
                    end else if (bus.rx_data == CMD_READ) begin
                        op_write_s = 1'b0;
                        state_s    = ST_GET_ADDR;
                    end else begin
                        tx_data_s  = RSP_ERR;
                        tx_valid_s = 1'b1;
                        state_s    = ST_SEND_ERR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (bus.rx_valid) begin
                    if (addr_bad_s) begin
                        // Remaining write bytes are left to the host; we answer now.
                        tx_data_s  = RSP_ERR;
                        tx_valid_s = 1'b1;
                        state_s    = ST_SEND_ERR;
                    end else if (op_write_r) begin
                        // Keep the bus address untouched until the write is complete.
                        addr_lat_s = bus.rx_data[ADDR_WIDTH-1:0];
                        state_s    = ST_GET_DHI;
                    end else begin
                        addr_s     = bus.rx_data[ADDR_WIDTH-1:0];
                        wait_cnt_s = {RL_WIDTH{1'b0}};
                        state_s    = ST_READ_WAIT;
                    end
                end else if (timeout_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_ADDR;
                end
            end
            ST_GET_DHI: begin
                if (bus.rx_valid) begin
                    dhi_s   = bus.rx_data;
                    state_s = ST_GET_DLO;
                end else if (timeout_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_DHI;
                end
            end
            ST_GET_DLO: begin
                if (bus.rx_valid) begin
                    addr_s    = addr_lat_r;
                    data_in_s = {dhi_r, bus.rx_data};
                    wen_s     = 1'b1;
                    state_s   = ST_WRITE;
                end else if (timeout_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_DLO;
                end
            end
            ST_WRITE: begin
                // wen is high during this state only; acknowledge follows.
                tx_data_s  = RSP_ACK;
                tx_valid_s = 1'b1;
                state_s    = ST_SEND_ACK;
            end
            ST_READ_WAIT: begin
                if (wait_cnt_r == RL_LAST) begin
                    tx_data_s  = bus.data_out[15:8];
                    hold_lo_s  = bus.data_out[7:0];
                    tx_valid_s = 1'b1;
                    state_s    = ST_SEND_HI;
                end else begin
                    wait_cnt_s = wait_cnt_r + RL_ONE;
                end
            end
            ST_SEND_HI: begin
                if (tx_accept_s) begin
                    tx_data_s = hold_lo_r;
                    state_s   = ST_SEND_LO;
                end else begin
                    state_s = ST_SEND_HI;
                end
            end
            ST_SEND_LO, ST_SEND_ACK, ST_SEND_ERR: begin
                if (tx_accept_s) begin
                    tx_valid_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                tx_valid_s = 1'b0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset drops any pending byte.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_r       <= ST_IDLE;
            op_write_r    <= 1'b0;
            addr_lat_r    <= {ADDR_WIDTH{1'b0}};
            dhi_r         <= 8'h00;
            hold_lo_r     <= 8'h00;
            wait_cnt_r    <= {RL_WIDTH{1'b0}};
            to_cnt_r      <= {TO_WIDTH{1'b0}};
            addr_r        <= {ADDR_WIDTH{1'b0}};
            data_in_r     <= {MEMORY_WIDTH{1'b0}};
            wen_r         <= 1'b0;
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            op_write_r    <= op_write_s;
            addr_lat_r    <= addr_lat_s;
            dhi_r         <= dhi_s;
            hold_lo_r     <= hold_lo_s;
            wait_cnt_r    <= wait_cnt_s;
            to_cnt_r      <= to_cnt_s;
            addr_r        <= addr_s;
            data_in_r     <= data_in_s;
            wen_r         <= wen_s;
            tx_data_r     <= tx_data_s;
            tx_valid_r    <= tx_valid_s;
            err_timeout_r <= err_timeout_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign bus.wen         = wen_r;
    assign bus.addr        = addr_r;
    assign bus.data_in     = data_in_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.tx_valid    = tx_valid_r;
    assign bus.busy        = busy_r;
    assign bus.err_timeout = err_timeout_r;
endmodule
